// File: rtl/apb_pwm_pkg.sv
// Shared definitions for the APB PWM peripheral and its configuration
// sequencer: register map, data width and sequencer state encoding.
package apb_pwm_pkg;

    localparam int DATA_W = 32;

    // PWM slave register map
    localparam logic [DATA_W-1:0] ADDR_CTRL   = 32'd0;
    localparam logic [DATA_W-1:0] ADDR_PERIOD = 32'd1;
    localparam logic [DATA_W-1:0] ADDR_DUTY   = 32'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } seq_state_t;

    // A configuration is usable only with a non-zero period and a duty
    // that fits inside it (duty == period means 100 % on).
    function automatic logic cfg_is_legal(input logic [DATA_W-1:0] period,
                                          input logic [DATA_W-1:0] duty);
        return (period != '0) && (duty <= period);
    endfunction

endpackage

// File: rtl/apb_pwm_sequencer.sv
// apb_pwm_sequencer: turns a one-cycle configuration request into three
// APB writes to the PWM slave (PERIOD, DUTY, then CTRL.enable).
// Optional feature: define PWM_SEQ_TIMEOUT_EN to abort a transfer whose
// ACCESS phase sees PREADY low for TIMEOUT_CYCLES consecutive cycles.
module apb_pwm_sequencer
    import apb_pwm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cfg_req,
    input  logic [DATA_W-1:0] cfg_period,
    input  logic [DATA_W-1:0] cfg_duty,
    input  logic              cfg_enable,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [DATA_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_t        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic              done_d, err_d;
    logic              latch_cfg;
    logic [DATA_W-1:0] period_q, duty_q;
    logic              enable_q;
    logic [DATA_W-1:0] period_src, duty_src;
    logic              enable_src;
    logic [DATA_W-1:0] paddr_d, pwdata_d;
    logic              psel_d, penable_d;

`ifdef PWM_SEQ_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

    // Next-state, write index and next registered-output decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        latch_cfg = 1'b0;
`ifdef PWM_SEQ_TIMEOUT_EN
        tcnt_d    = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_req) begin
                    if (cfg_is_legal(cfg_period, cfg_duty)) begin
                        state_d   = SETUP;
                        idx_d     = 2'd0;
                        latch_cfg = 1'b1;
`ifdef PWM_SEQ_TIMEOUT_EN
                        tcnt_d    = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
`ifdef PWM_SEQ_TIMEOUT_EN
                    tcnt_d = '0;
`endif
                    if (idx_q == 2'd2) begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SETUP;
                        idx_d   = idx_q + 2'd1;
                    end
                end
`ifdef PWM_SEQ_TIMEOUT_EN
                else if (tcnt_q == TCNT_LAST) begin
                    // Slave never answered: abandon the whole sequence
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    tcnt_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase

        // On acceptance the config registers are not loaded yet, so the
        // first SETUP takes its data straight from the request inputs.
        period_src = latch_cfg ? cfg_period : period_q;
        duty_src   = latch_cfg ? cfg_duty   : duty_q;
        enable_src = latch_cfg ? cfg_enable : enable_q;

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
        paddr_d   = '0;
        pwdata_d  = '0;
        if (psel_d) begin
            case (idx_d)
                2'd0: begin
                    paddr_d  = ADDR_PERIOD;
                    pwdata_d = period_src;
                end
                2'd1: begin
                    paddr_d  = ADDR_DUTY;
                    pwdata_d = duty_src;
                end
                2'd2: begin
                    paddr_d  = ADDR_CTRL;
                    pwdata_d = {{(DATA_W-1){1'b0}}, enable_src};
                end
                default: begin
                    paddr_d  = '0;
                    pwdata_d = '0;
                end
            endcase
        end
    end

    // State, index, timeout counter and all registered outputs
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
`ifdef PWM_SEQ_TIMEOUT_EN
            tcnt_q   <= '0;
`endif
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
`ifdef PWM_SEQ_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
`endif
            cfg_busy <= psel_d;
            cfg_done <= done_d;
            cfg_err  <= err_d;
            PSEL     <= psel_d;
            PENABLE  <= penable_d;
            PWRITE   <= psel_d;
            PADDR    <= paddr_d;
            PWDATA   <= pwdata_d;
        end
    end

    // Capture the accepted configuration; data only, so no reset needed
    always_ff @(posedge PCLK) begin
        if (latch_cfg) begin
            period_q <= cfg_period;
            duty_q   <= cfg_duty;
            enable_q <= cfg_enable;
        end
    end

endmodule

// File: tb/tb_apb_pwm_sequencer.sv
// Directed bench for apb_pwm_sequencer with a behavioural APB PWM slave.
// Honours PWM_SEQ_TIMEOUT_EN: with it defined the DUT is built with
// TIMEOUT_CYCLES=4 and the abort path is exercised.
module tb_apb_pwm_sequencer;
    import apb_pwm_pkg::*;

`ifdef PWM_SEQ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 16;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cfg_req;
    logic [31:0] cfg_period;
    logic [31:0] cfg_duty;
    logic        cfg_enable;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PREADY;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t wr_log[$];

    // behavioural PWM slave
    logic [31:0] s_ctrl, s_period, s_duty, pcnt;
    logic        pwm_out;

    apb_pwm_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cfg_req    (cfg_req),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_enable (cfg_enable),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Completed APB writes, as the slave sees them
    always @(posedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && PREADY && PWRITE)
            wr_log.push_back('{PADDR, PWDATA});
    end

    // Slave register file and PWM generator
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            s_ctrl   <= '0;
            s_period <= '0;
            s_duty   <= '0;
            pcnt     <= '0;
            pwm_out  <= 1'b0;
        end else begin
            if (PSEL && PENABLE && PREADY && PWRITE) begin
                if (PADDR == ADDR_CTRL)   s_ctrl   <= PWDATA;
                if (PADDR == ADDR_PERIOD) s_period <= PWDATA;
                if (PADDR == ADDR_DUTY)   s_duty   <= PWDATA;
            end
            if (s_ctrl[0] && s_period != 0) begin
                pcnt    <= (pcnt >= s_period - 1) ? 32'd0 : pcnt + 32'd1;
                pwm_out <= (pcnt < s_duty);
            end else begin
                pcnt    <= '0;
                pwm_out <= 1'b0;
            end
        end
    end

    // done and err must never coincide
    always @(negedge PCLK) begin
        if (PRESETn && (cfg_done || cfg_err))
            check("done_err_excl", {31'b0, cfg_done & cfg_err}, 32'd0);
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    // Pulse cfg_req across one edge; afterwards cyc==1 is the cycle after it
    task automatic issue(input logic [31:0] p, input logic [31:0] d, input logic e);
        cfg_period = p;
        cfg_duty   = d;
        cfg_enable = e;
        cfg_req    = 1'b1;
        tick();
        cfg_req    = 1'b0;
        cyc        = 1;
    endtask

    task automatic wait_done(input int limit, output logic saw_err);
        saw_err = 1'b0;
        while (!cfg_done && cyc < limit) begin
            if (cfg_err) saw_err = 1'b1;
            tick();
        end
    endtask

    task automatic check_apb(input string tag, input logic sel, input logic en,
                             input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_psel"},    {31'b0, PSEL},    {31'b0, sel});
        check({tag, "_penable"}, {31'b0, PENABLE}, {31'b0, en});
        check({tag, "_pwrite"},  {31'b0, PWRITE},  {31'b0, sel});
        check({tag, "_paddr"},   PADDR,  addr);
        check({tag, "_pwdata"},  PWDATA, data);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] p,
                                input logic [31:0] d, input logic e);
        check({tag, "_wr_count"}, 32'(wr_log.size()), 32'd3);
        if (wr_log.size() >= 3) begin
            check({tag, "_wr0_addr"}, wr_log[0].addr, 32'd1);
            check({tag, "_wr0_data"}, wr_log[0].data, p);
            check({tag, "_wr1_addr"}, wr_log[1].addr, 32'd2);
            check({tag, "_wr1_data"}, wr_log[1].data, d);
            check({tag, "_wr2_addr"}, wr_log[2].addr, 32'd0);
            check({tag, "_wr2_data"}, wr_log[2].data, {31'b0, e});
        end
    endtask

    initial begin
        logic saw_err;
        logic done_seen;
        logic prev_pwm;
        int   toggles;

        PRESETn    = 1'b0;
        cfg_req    = 1'b0;
        cfg_period = '0;
        cfg_duty   = '0;
        cfg_enable = 1'b0;
        PREADY     = 1'b1;
        tick();
        tick();
        check_apb("rst", 1'b0, 1'b0, 32'd0, 32'd0);
        check("rst_busy", {31'b0, cfg_busy}, 32'd0);
        check("rst_done", {31'b0, cfg_done}, 32'd0);
        check("rst_err",  {31'b0, cfg_err},  32'd0);
        PRESETn = 1'b1;
        tick();
        check("rst_exit_done", {31'b0, cfg_done}, 32'd0);
        check("rst_exit_err",  {31'b0, cfg_err},  32'd0);

        // zero-wait sequence
        wr_log.delete();
        issue(32'd120, 32'd5, 1'b1);
        check_apb("t1_setup0", 1'b1, 1'b0, 32'd1, 32'd120);
        check("t1_busy", {31'b0, cfg_busy}, 32'd1);
        tick();
        check_apb("t1_access0", 1'b1, 1'b1, 32'd1, 32'd120);
        tick();
        check_apb("t1_setup1", 1'b1, 1'b0, 32'd2, 32'd5);
        wait_done(50, saw_err);
        check("t1_done_cycle", 32'(cyc), 32'd7);
        check("t1_done", {31'b0, cfg_done}, 32'd1);
        check("t1_err", {31'b0, saw_err}, 32'd0);
        check_apb("t1_idle", 1'b0, 1'b0, 32'd0, 32'd0);
        check("t1_idle_busy", {31'b0, cfg_busy}, 32'd0);
        check_writes("t1", 32'd120, 32'd5, 1'b1);
        tick();
        check("t1_done_pulse", {31'b0, cfg_done}, 32'd0);
        toggles  = 0;
        prev_pwm = pwm_out;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (pwm_out !== prev_pwm) toggles++;
            prev_pwm = pwm_out;
        end
        check("t1_pwm_toggling", {31'b0, (toggles >= 2)}, 32'd1);

        // three wait states on the DUTY write
        wr_log.delete();
        issue(32'd120, 32'd5, 1'b1);
        tick();
        tick();
        check_apb("t2_setup1", 1'b1, 1'b0, 32'd2, 32'd5);
        PREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_apb("t2_wait", 1'b1, 1'b1, 32'd2, 32'd5);
        end
        tick();
        check_apb("t2_access1", 1'b1, 1'b1, 32'd2, 32'd5);
        PREADY = 1'b1;
        wait_done(50, saw_err);
        check("t2_done_cycle", 32'(cyc), 32'd10);
        check("t2_err", {31'b0, saw_err}, 32'd0);
        check_writes("t2", 32'd120, 32'd5, 1'b1);

        // slave that never answers
        wr_log.delete();
        PREADY = 1'b0;
        issue(32'd120, 32'd5, 1'b1);
        check_apb("t3_setup0", 1'b1, 1'b0, 32'd1, 32'd120);
`ifdef PWM_SEQ_TIMEOUT_EN
        for (int i = 0; i < 4; i++) tick();
        check_apb("t3_access_last", 1'b1, 1'b1, 32'd1, 32'd120);
        tick();
        check_apb("t3_abort", 1'b0, 1'b0, 32'd0, 32'd0);
        check("t3_err", {31'b0, cfg_err}, 32'd1);
        check("t3_busy", {31'b0, cfg_busy}, 32'd0);
        done_seen = cfg_done;
        tick();
        check("t3_err_pulse", {31'b0, cfg_err}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (cfg_done) done_seen = 1'b1;
            tick();
        end
        check("t3_no_done", {31'b0, done_seen}, 32'd0);
        check("t3_no_writes", 32'(wr_log.size()), 32'd0);
        PREADY = 1'b1;
`else
        saw_err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cfg_err) saw_err = 1'b1;
        end
        check_apb("t3_still_waiting", 1'b1, 1'b1, 32'd1, 32'd120);
        check("t3_no_err", {31'b0, saw_err}, 32'd0);
        PREADY = 1'b1;
        wait_done(80, saw_err);
        check("t3_done_cycle", 32'(cyc), 32'd26);
        check_writes("t3", 32'd120, 32'd5, 1'b1);
`endif

        // illegal configurations, then the duty==period boundary
        wr_log.delete();
        issue(32'd10, 32'd11, 1'b1);
        check("t4_duty_gt_err", {31'b0, cfg_err}, 32'd1);
        check("t4_duty_gt_psel", {31'b0, PSEL}, 32'd0);
        check("t4_duty_gt_busy", {31'b0, cfg_busy}, 32'd0);
        tick();
        check("t4_err_pulse", {31'b0, cfg_err}, 32'd0);
        check("t4_psel_after", {31'b0, PSEL}, 32'd0);
        issue(32'd0, 32'd0, 1'b1);
        check("t4_period0_err", {31'b0, cfg_err}, 32'd1);
        check("t4_period0_psel", {31'b0, PSEL}, 32'd0);
        tick();
        check("t4_no_writes", 32'(wr_log.size()), 32'd0);
        issue(32'd7, 32'd7, 1'b1);
        check("t4_eq_no_err", {31'b0, cfg_err}, 32'd0);
        wait_done(50, saw_err);
        check("t4_eq_done_cycle", 32'(cyc), 32'd7);
        check_writes("t4", 32'd7, 32'd7, 1'b1);

        // second request while busy is dropped
        wr_log.delete();
        issue(32'd50, 32'd20, 1'b1);
        tick();
        cfg_period = 32'd99;
        cfg_duty   = 32'd1;
        cfg_enable = 1'b0;
        cfg_req    = 1'b1;
        tick();
        cfg_req    = 1'b0;
        wait_done(50, saw_err);
        check("t5_done_cycle", 32'(cyc), 32'd7);
        check("t5_err", {31'b0, saw_err}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("t5_idle_busy", {31'b0, cfg_busy}, 32'd0);
        check_writes("t5", 32'd50, 32'd20, 1'b1);

        // asynchronous reset in the middle of ACCESS
        issue(32'd120, 32'd5, 1'b1);
        tick();
        check_apb("t6_in_access", 1'b1, 1'b1, 32'd1, 32'd120);
        #2;
        PRESETn = 1'b0;
        #1;
        check_apb("t6_async_rst", 1'b0, 1'b0, 32'd0, 32'd0);
        check("t6_rst_busy", {31'b0, cfg_busy}, 32'd0);
        tick();
        PRESETn = 1'b1;
        tick();
        check("t6_exit_done", {31'b0, cfg_done}, 32'd0);
        check("t6_exit_err",  {31'b0, cfg_err},  32'd0);
        check_apb("t6_exit_idle", 1'b0, 1'b0, 32'd0, 32'd0);
        wr_log.delete();
        issue(32'd30, 32'd10, 1'b0);
        wait_done(50, saw_err);
        check("t6_done_cycle", 32'(cyc), 32'd7);
        check("t6_err", {31'b0, saw_err}, 32'd0);
        check_writes("t6", 32'd30, 32'd10, 1'b0);
        toggles  = 0;
        prev_pwm = pwm_out;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pwm_out !== prev_pwm) toggles++;
            prev_pwm = pwm_out;
        end
        check("t6_pwm_disabled", 32'(toggles), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_pwm_sequencer.md
APB_PWM_SEQUENCER -- requirements
Module: apb_pwm_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max consecutive ACCESS cycles with PREADY low before abort.
REQ-002 SHALL have port PCLK  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port PRESETn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cfg_req  input  1  one-cycle configuration request.
REQ-005 SHALL have port cfg_period  input  32  PWM period value.
REQ-006 SHALL have port cfg_duty  input  32  PWM duty value.
REQ-007 SHALL have port cfg_enable  input  1  PWM enable value.
REQ-008 SHALL have port cfg_busy  output  1  sequence in progress.
REQ-009 SHALL have port cfg_done  output  1  one-cycle pulse, all three writes completed.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse, request rejected or timed out.
REQ-011 SHALL have ports PADDR output 32, PWRITE output 1, PSEL output 1, PENABLE output 1, PWDATA output 32: APB master request.
REQ-012 SHALL have port PREADY  input  1  APB slave ready.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS, plus a 2-bit write index 0..2.
REQ-014 SHALL accept cfg_req only in IDLE, and SHALL register cfg_period/cfg_duty/cfg_enable on acceptance; requests while busy SHALL be ignored.
REQ-015 SHALL reject the request if cfg_period==0 or cfg_duty>cfg_period: cfg_err pulse next cycle, no APB activity, stay IDLE. duty==period is legal.
REQ-016 SHALL issue writes in order: index0 PADDR=1/PWDATA=period, index1 PADDR=2/PWDATA=duty, index2 PADDR=0/PWDATA={31'b0,enable}.
REQ-017 SETUP SHALL drive PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA valid; SETUP SHALL always transition to ACCESS after exactly one cycle.
REQ-018 ACCESS SHALL drive PSEL=1, PENABLE=1, with PADDR/PWDATA/PWRITE held stable until PREADY=1 is sampled.
REQ-019 On PREADY=1 in ACCESS: index<2 -> SETUP with index+1 (PSEL stays 1, PENABLE drops); index==2 -> IDLE with cfg_done pulse in the following cycle.
REQ-020 With zero-wait slave: request at edge N, first SETUP cycle N+1, cfg_done high in cycle N+7.
REQ-021 All outputs SHALL be registered; in IDLE PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0.
REQ-022 cfg_busy SHALL be 1 in SETUP and ACCESS, 0 in IDLE.
REQ-023 cfg_done and cfg_err SHALL never assert in the same cycle.

Reset
REQ-024 PRESETn low SHALL asynchronously force IDLE, index=0, timeout counter=0, and all outputs to 0, including mid-transfer; no cfg_done/cfg_err SHALL pulse on reset exit.

Configuration
REQ-025 With PWM_SEQ_TIMEOUT_EN defined: counter increments each ACCESS cycle with PREADY=0 and clears on entry to SETUP. When it reaches TIMEOUT_CYCLES, the FSM SHALL drop PSEL/PENABLE, go to IDLE, and pulse cfg_err with no cfg_done.
REQ-026 Without PWM_SEQ_TIMEOUT_EN: no counter, ACCESS SHALL wait for PREADY indefinitely, and cfg_err SHALL assert only per REQ-015.

Structure
REQ-027 A shared package apb_pwm_pkg SHALL hold register address constants (ADDR_CTRL=0, ADDR_PERIOD=1, ADDR_DUTY=2) and the FSM state typedef; the APB_PWM slave SHALL use the same constants.
REQ-028 No sub-module is required; the timeout counter SHALL remain inline.

Verification
REQ-029 Bench SHALL cover: period=120, duty=5, enable=1, PREADY tied 1 -> APB writes (1,120),(2,5),(0,1), cfg_done at N+7, PWM_OUT toggling on the APB_PWM slave.
REQ-030 Bench SHALL cover: same request, PREADY low 3 cycles on the second write -> PADDR=2/PWDATA=5 held stable, cfg_done at N+10.
REQ-031 Bench SHALL cover: timeout enabled, TIMEOUT_CYCLES=4, PREADY stuck 0 -> PSEL drops after 4 ACCESS cycles, cfg_err pulse, cfg_done never asserts.
REQ-032 Bench SHALL cover: period=10, duty=11 -> cfg_err at N+1, PSEL never asserts; then period=0 -> cfg_err.
REQ-033 Bench SHALL cover: second cfg_req during busy -> ignored, only the first config written; PRESETn pulsed low mid-ACCESS -> all outputs 0 immediately, next request completes normally.
